// File: rtl/vga_pkg.sv
// Shared VGA constants: resolution, colour width, flash defaults
// and the game's sprite layer indices (0 = top of the stack).
package vga_pkg;
    localparam int H_RES          = 640;
    localparam int V_RES          = 480;
    localparam int COLOR_W        = 3;
    localparam int FLASH_FRAMES   = 8;
    localparam int FC_W           = 8;
    localparam int LAYER_COUNT    = 6;
    localparam int LAYER_USER     = 0;
    localparam int LAYER_BULLET   = 1;
    localparam int LAYER_SPIDER   = 2;
    localparam int LAYER_MOSQUITO = 3;
    localparam int LAYER_FLY      = 4;
endpackage

// File: rtl/pixel_layer_compositor_if.sv
// Composited pixel bus towards the VGA pins.
interface pixel_layer_compositor_if #(
    parameter int COLOR_W = vga_pkg::COLOR_W
);
    logic [COLOR_W-1:0] rgb_out;
    logic               hsync_out;
    logic               vsync_out;
    logic               video_on_out;

    modport master (
        output rgb_out,
        output hsync_out,
        output vsync_out,
        output video_on_out
    );

    modport slave (
        input rgb_out,
        input hsync_out,
        input vsync_out,
        input video_on_out
    );
endinterface

// File: rtl/pixel_layer_compositor_flash.sv
// Single-layer hit-flash timer: reloads on trigger, steps down once per
// frame tick and blanks its layer while the count is odd.
module layer_flash_timer
    import vga_pkg::*;
#(
    parameter int LOAD_VAL = FLASH_FRAMES
) (
    input  logic clk25,
    input  logic reset_n,
    input  logic trigger,
    input  logic tick,
    output logic blank,
    output logic active
);
    localparam logic [FC_W-1:0] LOAD = FC_W'(LOAD_VAL);

    logic [FC_W-1:0] fc_q, fc_d;
    logic            active_q, active_d;

    always_comb begin
        fc_d = fc_q;
        if (trigger) begin
            fc_d = LOAD;
        end else if (tick && fc_q != '0) begin
            fc_d = fc_q - FC_W'(1);
        end
        active_d = (fc_d != '0);
    end

    always_ff @(posedge clk25) begin
        if (!reset_n) begin
            fc_q     <= '0;
            active_q <= 1'b0;
        end else begin
            fc_q     <= fc_d;
            active_q <= active_d;
        end
    end

    // an odd count is necessarily nonzero
    assign blank  = fc_q[0];
    assign active = active_q;
endmodule

// File: rtl/pixel_layer_compositor.sv
// Two-stage sprite layer compositor: lowest visible layer index wins,
// syncs and blanking are delayed alongside the colour.
module pixel_layer_compositor #(
    parameter int                 LAYER_COUNT  = 6,
    parameter int                 COLOR_W      = vga_pkg::COLOR_W,
    parameter int                 FLASH_FRAMES = vga_pkg::FLASH_FRAMES,
    parameter logic [COLOR_W-1:0] BG_COLOR     = '0,
    localparam int IDX_W = (LAYER_COUNT > 1) ? $clog2(LAYER_COUNT) : 1
) (
    input  logic                           clk25,
    input  logic                           reset_n,
    input  logic [LAYER_COUNT*COLOR_W-1:0] layer_rgb_flat,
    input  logic [LAYER_COUNT-1:0]         layer_valid,
    input  logic [LAYER_COUNT-1:0]         layer_enable,
    input  logic [LAYER_COUNT-1:0]         flash_trigger,
    input  logic                           hsync_in,
    input  logic                           vsync_in,
    input  logic                           video_on_in,
    pixel_layer_compositor_if.master       vga,
    output logic [IDX_W-1:0]               top_layer,
    output logic                           top_hit,
    output logic [LAYER_COUNT-1:0]         flashing
);
    logic                           frame_tick;
    logic [LAYER_COUNT-1:0]         blank;

    logic [LAYER_COUNT-1:0]         s1_eff_q, s1_eff_d;
    logic [LAYER_COUNT*COLOR_W-1:0] s1_rgb_q, s1_rgb_d;
    logic                           s1_hs_q, s1_hs_d;
    logic                           s1_vs_q, s1_vs_d;
    logic                           s1_von_q, s1_von_d;

    logic [COLOR_W-1:0]             pix_c;
    logic [COLOR_W-1:0]             rgb_q, rgb_d;
    logic [IDX_W-1:0]               top_q, top_d;
    logic                           hit_q, hit_d;
    logic                           hs_q, hs_d;
    logic                           vs_q, vs_d;
    logic                           von_q, von_d;

    for (genvar g = 0; g < LAYER_COUNT; g++) begin : g_flash
        layer_flash_timer #(
            .LOAD_VAL (FLASH_FRAMES)
        ) u_timer (
            .clk25   (clk25),
            .reset_n (reset_n),
            .trigger (flash_trigger[g]),
            .tick    (frame_tick),
            .blank   (blank[g]),
            .active  (flashing[g])
        );
    end

    // s1_vs_q doubles as the vsync edge detector; it idles high
    always_comb begin
        frame_tick = s1_vs_q & ~vsync_in;
        s1_eff_d   = layer_valid & layer_enable & ~blank;
        s1_rgb_d   = layer_rgb_flat;
        s1_hs_d    = hsync_in;
        s1_vs_d    = vsync_in;
        s1_von_d   = video_on_in;
    end

    always_comb begin
        hit_d = 1'b0;
        top_d = '0;
        pix_c = BG_COLOR;
        for (int i = LAYER_COUNT - 1; i >= 0; i--) begin
            if (s1_eff_q[i]) begin
                hit_d = 1'b1;
                top_d = IDX_W'(i);
                pix_c = s1_rgb_q[i*COLOR_W +: COLOR_W];
            end
        end
        rgb_d = pix_c & {COLOR_W{s1_von_q}};
        hs_d  = s1_hs_q;
        vs_d  = s1_vs_q;
        von_d = s1_von_q;
    end

    always_ff @(posedge clk25) begin
        if (!reset_n) begin
            s1_eff_q <= '0;
            s1_rgb_q <= '0;
            s1_hs_q  <= 1'b1;
            s1_vs_q  <= 1'b1;
            s1_von_q <= 1'b0;
            rgb_q    <= '0;
            top_q    <= '0;
            hit_q    <= 1'b0;
            hs_q     <= 1'b1;
            vs_q     <= 1'b1;
            von_q    <= 1'b0;
        end else begin
            s1_eff_q <= s1_eff_d;
            s1_rgb_q <= s1_rgb_d;
            s1_hs_q  <= s1_hs_d;
            s1_vs_q  <= s1_vs_d;
            s1_von_q <= s1_von_d;
            rgb_q    <= rgb_d;
            top_q    <= top_d;
            hit_q    <= hit_d;
            hs_q     <= hs_d;
            vs_q     <= vs_d;
            von_q    <= von_d;
        end
    end

    assign vga.rgb_out      = rgb_q;
    assign vga.hsync_out    = hs_q;
    assign vga.vsync_out    = vs_q;
    assign vga.video_on_out = von_q;
    assign top_layer        = top_q;
    assign top_hit          = hit_q;
endmodule

// File: tb/tb_pixel_layer_compositor.sv
// Bench for pixel_layer_compositor: per-cycle reference model plus
// directed literal checks of priority, enable, blanking and flashing.
module tb_pixel_layer_compositor;
    localparam int          LC = 6;
    localparam int          CW = 3;
    localparam int          FF = 4;
    localparam logic [2:0]  BG = 3'b011;

    logic clk25 = 1'b0;
    always #20 clk25 = ~clk25;

    logic              reset_n;
    logic [LC*CW-1:0]  layer_rgb_flat;
    logic [LC-1:0]     layer_valid, layer_enable, flash_trigger;
    logic              hsync_in, vsync_in, video_on_in;
    logic [2:0]        top_layer;
    logic              top_hit;
    logic [LC-1:0]     flashing;

    pixel_layer_compositor_if #(.COLOR_W(CW)) vga();

    pixel_layer_compositor #(
        .LAYER_COUNT  (LC),
        .COLOR_W      (CW),
        .FLASH_FRAMES (FF),
        .BG_COLOR     (BG)
    ) dut (
        .clk25          (clk25),
        .reset_n        (reset_n),
        .layer_rgb_flat (layer_rgb_flat),
        .layer_valid    (layer_valid),
        .layer_enable   (layer_enable),
        .flash_trigger  (flash_trigger),
        .hsync_in       (hsync_in),
        .vsync_in       (vsync_in),
        .video_on_in    (video_on_in),
        .vga            (vga),
        .top_layer      (top_layer),
        .top_hit        (top_hit),
        .flashing       (flashing)
    );

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [2:0] rgb;
        logic       hs;
        logic       vs;
        logic       von;
        logic [2:0] top;
        logic       hit;
    } px_t;

    localparam px_t RST_PX = '{rgb: 3'b000, hs: 1'b1, vs: 1'b1,
                               von: 1'b0, top: 3'd0, hit: 1'b0};

    px_t       pend, expo;
    int        fc_m [LC];
    bit        prev_vs;
    bit        model_ok = 1'b0;
    logic [LC-1:0] exp_fl;

    // Reference: a pixel's result appears one edge after the edge that
    // samples it; flash counters are plain integers per layer.
    always @(posedge clk25) begin
        px_t  r;
        bit   tick;
        int   nfc;
        logic [LC-1:0] fl;
        if (!reset_n) begin
            for (int i = 0; i < LC; i++) fc_m[i] <= 0;
            prev_vs  <= 1'b1;
            pend     <= RST_PX;
            expo     <= RST_PX;
            exp_fl   <= '0;
            model_ok <= 1'b1;
        end else begin
            tick = prev_vs && !vsync_in;
            r = '{rgb: BG, hs: hsync_in, vs: vsync_in,
                  von: video_on_in, top: 3'd0, hit: 1'b0};
            for (int i = LC - 1; i >= 0; i--) begin
                if (layer_valid[i] && layer_enable[i] && (fc_m[i] % 2 == 0)) begin
                    r.hit = 1'b1;
                    r.top = 3'(i);
                    r.rgb = layer_rgb_flat[i*CW +: CW];
                end
            end
            if (!video_on_in) r.rgb = 3'b000;
            expo <= pend;
            pend <= r;
            for (int i = 0; i < LC; i++) begin
                if (flash_trigger[i])           nfc = FF;
                else if (tick && fc_m[i] > 0)   nfc = fc_m[i] - 1;
                else                            nfc = fc_m[i];
                fc_m[i] <= nfc;
                fl[i] = (nfc != 0);
            end
            exp_fl  <= fl;
            prev_vs <= vsync_in;
        end
    end

    always @(negedge clk25) begin
        if (model_ok) begin
            tests++;
            if ({vga.rgb_out, vga.hsync_out, vga.vsync_out, vga.video_on_out,
                 top_layer, top_hit} !== expo || flashing !== exp_fl) begin
                fails++;
                $display("FAIL cycle_model t=%0t got rgb=%b hs=%b vs=%b von=%b top=%0d hit=%b fl=%b want rgb=%b hs=%b vs=%b von=%b top=%0d hit=%b fl=%b",
                         $time, vga.rgb_out, vga.hsync_out, vga.vsync_out,
                         vga.video_on_out, top_layer, top_hit, flashing,
                         expo.rgb, expo.hs, expo.vs, expo.von, expo.top,
                         expo.hit, exp_fl);
            end
        end
    end

    task automatic chk(string name, logic [31:0] got, logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic cyc(int n);
        repeat (n) @(negedge clk25);
    endtask

    task automatic rand_inputs();
        layer_rgb_flat = LC*CW'($urandom);
        layer_valid    = LC'($urandom);
        layer_enable   = LC'($urandom) | LC'($urandom);
        flash_trigger  = LC'($urandom);
        hsync_in       = 1'($urandom);
        vsync_in       = 1'($urandom);
        video_on_in    = 1'($urandom);
    endtask

    task automatic frame();
        vsync_in = 1'b0;
        cyc(2);
        vsync_in = 1'b1;
        cyc(8);
    endtask

    initial begin
        int n;
        reset_n = 1'b0;
        rand_inputs();
        for (int k = 0; k < 4; k++) begin
            cyc(1);
            chk("rst_rgb", vga.rgb_out, 0);
            chk("rst_hs", vga.hsync_out, 1);
            chk("rst_vs", vga.vsync_out, 1);
            chk("rst_hit", top_hit, 0);
            chk("rst_flashing", flashing, 0);
            rand_inputs();
        end

        layer_valid   = '0;
        layer_enable  = '1;
        flash_trigger = '0;
        hsync_in      = 1'b1;
        vsync_in      = 1'b1;
        video_on_in   = 1'b1;
        reset_n       = 1'b1;
        cyc(3);
        chk("bg_idle", vga.rgb_out, BG);

        layer_rgb_flat = {3'b110, 3'b111, 3'b001, 3'b010, 3'b100, 3'b001};
        layer_valid    = 6'b010110;
        cyc(2);
        chk("prio_rgb", vga.rgb_out, 3'b100);
        chk("prio_top", top_layer, 1);
        chk("prio_hit", top_hit, 1);

        layer_enable = 6'b111101;
        cyc(2);
        chk("en_rgb", vga.rgb_out, 3'b010);
        chk("en_top", top_layer, 2);

        video_on_in = 1'b0;
        cyc(2);
        chk("blank_rgb", vga.rgb_out, 0);

        video_on_in  = 1'b1;
        layer_enable = '1;
        layer_valid  = 6'b000001;
        layer_rgb_flat[2:0] = 3'b101;
        flash_trigger[0] = 1'b1;
        cyc(1);
        flash_trigger[0] = 1'b0;
        cyc(4);
        chk("flash_f1_rgb", vga.rgb_out, 3'b101);
        chk("flash_f1_fl", flashing[0], 1);
        frame();
        chk("flash_f2_rgb", vga.rgb_out, BG);
        frame();
        chk("flash_f3_rgb", vga.rgb_out, 3'b101);
        frame();
        chk("flash_f4_rgb", vga.rgb_out, BG);
        chk("flash_f4_fl", flashing[0], 1);
        frame();
        chk("flash_end_rgb", vga.rgb_out, 3'b101);
        chk("flash_end_fl", flashing[0], 0);
        frame();
        chk("flash_solid_rgb", vga.rgb_out, 3'b101);

        flash_trigger[3] = 1'b1;
        cyc(1);
        flash_trigger[3] = 1'b0;
        frame();
        frame();
        frame();
        chk("sim_pre_fl", flashing[3], 1);
        vsync_in         = 1'b0;
        flash_trigger[3] = 1'b1;
        cyc(1);
        flash_trigger[3] = 1'b0;
        cyc(1);
        vsync_in = 1'b1;
        cyc(8);
        n = 0;
        while (flashing[3] && n < 10) begin
            frame();
            n++;
        end
        chk("sim_reload_frames", n, FF);

        flash_trigger = '1;
        cyc(1);
        flash_trigger = '0;
        cyc(1);
        chk("midrst_pre_fl", flashing, 6'h3f);
        reset_n = 1'b0;
        cyc(1);
        chk("midrst_fl", flashing, 0);
        reset_n = 1'b1;
        cyc(2);

        for (int c = 0; c < 4000; c++) begin
            layer_rgb_flat = LC*CW'($urandom);
            layer_valid    = LC'($urandom);
            layer_enable   = LC'($urandom) | LC'($urandom);
            flash_trigger  = ($urandom_range(0, 25) == 0) ?
                             LC'(1 << $urandom_range(0, LC - 1)) : '0;
            hsync_in       = 1'($urandom);
            if ($urandom_range(0, 7) == 0) vsync_in = ~vsync_in;
            video_on_in    = ($urandom_range(0, 5) != 0);
            reset_n        = ($urandom_range(0, 499) != 0);
            cyc(1);
        end
        reset_n = 1'b1;
        cyc(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/pixel_layer_compositor.md
# pixel_layer_compositor

- Parametrised, pipelined pixel compositor that replaces the fixed user→bullet→spider→mosquito→fly priority mux in the game top level.
- Merges `LAYER_COUNT` sprite layers into one output colour, using index priority (layer 0 is the top layer).
- Supports per-layer enable and a per-layer hit-flash effect that blinks a layer for a programmable number of frames.
- Delays hsync, vsync and video_on by the same pipeline depth, so timing stays aligned with pixel colour at the VGA pins.

## Interface
Parameters:
- `LAYER_COUNT`, 6: number of layers; index 0 has the highest priority.
- `COLOR_W`, 3: packed colour width per layer (3 = {R,G,B}).
- `FLASH_FRAMES`, 8: frames a layer blinks after a trigger; legal range 1..255.
- `BG_COLOR`, 0: colour driven when no layer is visible.

Ports:
- `clk25`  in  1: 25 MHz pixel clock. One clock domain only.
- `reset_n`  in  1: synchronous, active-low reset.
- `layer_rgb_flat`  in  LAYER_COUNT*COLOR_W: layer i colour is at `[i*COLOR_W +: COLOR_W]`.
- `layer_valid`  in  LAYER_COUNT: layer i has an opaque pixel at the current x/y.
- `layer_enable`  in  LAYER_COUNT: static per-layer enable; 0 hides the layer.
- `flash_trigger`  in  LAYER_COUNT: one-cycle pulse; starts or restarts the flash of layer i.
- `hsync_in`, `vsync_in`, `video_on_in`  in  1 each: signals from vga_controller, active-low syncs.
- `rgb_out`  out  COLOR_W: composited colour; forced to 0 when `video_on_out`=0.
- `hsync_out`, `vsync_out`, `video_on_out`  out  1 each: the input signals delayed 2 cycles.
- `top_layer`  out  $clog2(LAYER_COUNT): index of the winning layer; 0 when none is visible.
- `top_hit`  out  1: 1 when some layer is visible.
- `flashing`  out  LAYER_COUNT: layer i flash counter is nonzero.

## Operation
- **Frame tick:** the cycle where registered `vsync_in` was 1 and current `vsync_in` is 0 (falling edge). It fires once per frame.
- **Flash counter:** layer i has an 8-bit counter `fc[i]`.
  - `flash_trigger[i]` loads `FLASH_FRAMES`.
  - Otherwise, a frame tick with `fc[i]`≠0 decrements it.
  - Trigger and frame tick in the same cycle: the load wins.
  - A retrigger while flashing reloads the counter. It is not additive.
  - The counter saturates at 0 and never wraps.
- **Flash blank:** layer i is blanked while `fc[i][0]`=1, which blinks it at frame rate. Blanking ends when `fc[i]` reaches 0.
- **Effective valid:** `eff[i] = layer_valid[i] & layer_enable[i] & ~(fc[i]≠0 & fc[i][0])`.
- **Stage 1 (registered):** the `eff` vector, the colours, and the three sync/blank signals.
- **Stage 2 (registered):** priority encode; the lowest set index wins.
  - `rgb_out` = winning colour, or `BG_COLOR` if there is no winner.
  - The result is ANDed with the stage-1 video_on.
  - `top_layer` and `top_hit` are updated; the syncs are passed through.
- **Reset:**
  - All `fc`, pipeline registers and the edge-detect register clear, except those noted next.
  - `hsync_out` and `vsync_out` reset to 1 (idle), and so do the stage-1 sync registers and the vsync edge-detect register. This means no false frame tick on the first cycle after reset.
  - All other outputs reset to 0.
  - Triggers during reset are ignored.
  - Reset mid-flash abandons the flash.

## Timing
- Latency is 2 cycles from any pixel input to `rgb_out`, `top_layer` and `top_hit`. It is the same 2 cycles for every sync and blank signal.
- Throughput is 1 pixel per cycle. There is no stall or handshake.
- A `flash_trigger` in cycle t affects the `eff` computed in cycle t+1. It is therefore visible at `rgb_out` in t+3.
- The first frame after a trigger is visible (`FLASH_FRAMES` even, bit0=0). Blinking then alternates per frame.
- Total flash duration is exactly `FLASH_FRAMES` frame ticks.
- `flashing[i]` is registered and follows `fc[i]` directly: 1 the cycle after the load, 0 the cycle after the final decrement.

## Structure
- A shared `vga_pkg` holds:
  - the resolution constants (640x480);
  - `COLOR_W`;
  - the default `FLASH_FRAMES`;
  - the layer index constants (`LAYER_USER`=0, `LAYER_BULLET`=1, `LAYER_SPIDER`=2, `LAYER_MOSQUITO`=3, `LAYER_FLY`=4).
- One sub-module, `layer_flash_timer`, holds the single-layer 8-bit counter plus blank output. Generate `LAYER_COUNT` instances of it.
- The priority encoder is a for-loop in the parent module.

## Test plan
- **Reset:** hold `reset_n`=0 for 4 cycles with random inputs.
  - Required: `rgb_out`=0, `hsync_out`=`vsync_out`=1, `top_hit`=0, `flashing`=0.
- **Priority:**
  - Stimulus: `layer_valid`=6'b010110, colours L1=3'b100, L2=3'b010, `video_on_in`=1.
  - Required: 2 cycles later `rgb_out`=3'b100, `top_layer`=1, `top_hit`=1.
- **Enable and blank:**
  - `layer_enable[1]`=0 with the same stimulus → `rgb_out`=3'b010, `top_layer`=2.
  - `video_on_in`=0 → `rgb_out`=0.
- **Flash:**
  - Pulse `flash_trigger[0]` with `FLASH_FRAMES`=4 and layer 0 always valid, then run 5 frames.
  - Required: layer 0 visible / hidden / visible / hidden over frames 1–4, then solid. `flashing[0]` falls after the 4th tick.
- **Simultaneous trigger and tick:**
  - Stimulus: trigger layer 3 exactly on a vsync falling-edge cycle while `fc[3]`=1.
  - Required: `fc[3]`=`FLASH_FRAMES`, not 0 and not `FLASH_FRAMES-1`.
- **Alignment:** random hsync/vsync pattern.
  - Required: the outputs equal the inputs delayed exactly 2 cycles.
  - Reset asserted mid-flash clears `flashing` on the next cycle.
